io_gpio_ctrl: RTL

IO_GPIO_CTRL -- requirements
Module: io_gpio_ctrl

---
 rtl/io_gpio_ctrl.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/io_gpio_ctrl.sv
// io_gpio_ctrl: memory-mapped GPIO block with debounced push buttons,
// sticky rising-edge flags with a level interrupt, and LED outputs with
// set/clear aliases.
//
// Optional feature: define IO_GPIO_BLINK_EN to add a BLINK_MASK/BLINK_DIV
// pair and a 16-bit prescaler. The prescaler blanks the masked LEDs during
// the low half of the blink phase. Without the macro those registers read 0,
// ignore writes and generate no logic.
//
// Register window (64 bytes at BASE_ADDR, word offsets):
//   0x00 BTN_IN (RO)   0x04 BTN_EDGE (RW1C)  0x08 IRQ_EN (RW)  0x0C LED_OUT (RW)
//   0x10 LED_SET (WO)  0x14 LED_CLR (WO)     0x18 BLINK_MASK   0x1C BLINK_DIV[15:0]
module io_gpio_ctrl #(
  parameter int          NUM_BTN         = 4,
  parameter int          NUM_LED         = 4,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter logic [31:0] BASE_ADDR       = 32'h8000_0000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        io_addr,
  input  logic               io_we,
  input  logic [3:0]         io_be,
  input  logic [31:0]        io_wdata,
  output logic [31:0]        io_rdata,
  input  logic [NUM_BTN-1:0] push_keys,
  output logic [NUM_LED-1:0] leds,
  output logic               io_irq
);

  // Word offsets inside the register window.
  localparam logic [3:0] OFS_BTN_IN     = 4'd0;
  localparam logic [3:0] OFS_BTN_EDGE   = 4'd1;
  localparam logic [3:0] OFS_IRQ_EN     = 4'd2;
  localparam logic [3:0] OFS_LED_OUT    = 4'd3;
  localparam logic [3:0] OFS_LED_SET    = 4'd4;
  localparam logic [3:0] OFS_LED_CLR    = 4'd5;
  localparam logic [3:0] OFS_BLINK_MASK = 4'd6;
  localparam logic [3:0] OFS_BLINK_DIV  = 4'd7;

  // The counter only ever holds 0..DEBOUNCE_CYCLES-1: the cycle it would
  // reach DEBOUNCE_CYCLES is the cycle the new level is accepted.
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------
  logic        sel;
  logic        wr;
  logic [3:0]  ofs;
  logic [31:0] be_mask;
  logic [31:0] wbits;

  assign sel     = (io_addr[31:6] == BASE_ADDR[31:6]);
  assign ofs     = io_addr[5:2];
  assign wr      = io_we & sel;
  assign be_mask = {{8{io_be[3]}}, {8{io_be[2]}}, {8{io_be[1]}}, {8{io_be[0]}}};
  assign wbits   = io_wdata & be_mask;

  // Byte-lane bits beyond the implemented register widths are dropped on
  // purpose; the address LSBs select nothing in a word-wide window.
  logic unused_bits;
  assign unused_bits = ^{io_addr[1:0], wbits};

  // ---------------------------------------------------------------------
  // Button synchroniser and debounce
  // ---------------------------------------------------------------------
  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] deb;
  logic [NUM_BTN-1:0] deb_next;
  logic [NUM_BTN-1:0] rise;
  logic [CNT_W-1:0]   cnt [NUM_BTN];

  // Two-flop synchroniser on the raw asynchronous button levels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      // NOTE: non-blocking assignments make sync2 take the old sync1, which
      // is what gives two real flop stages instead of one.
      sync1 <= push_keys;
      sync2 <= sync1;
    end
  end

  // Accept the synchronised level once it has differed for DEBOUNCE_CYCLES.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    deb_next = deb;
    for (int i = 0; i < NUM_BTN; i++) begin
      if ((sync2[i] != deb[i]) && (cnt[i] == CNT_LAST)) begin
        deb_next[i] = sync2[i];
      end
    end
  end

  assign rise = deb_next & ~deb;

  // Per-button stability counters and debounced levels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the counter array is reset explicitly; a partial count must
      // not survive reset, so it cannot be left as an unreset memory.
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt[i] <= '0;
      end
      deb <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if ((sync2[i] == deb[i]) || (cnt[i] == CNT_LAST)) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
      deb <= deb_next;
    end
  end

  // ---------------------------------------------------------------------
  // Edge flags, interrupt enable and LED register
  // ---------------------------------------------------------------------
  logic [NUM_BTN-1:0] btn_edge;
  logic [NUM_BTN-1:0] edge_clr;
  logic [NUM_BTN-1:0] irq_en;
  logic [NUM_LED-1:0] led_out;

  // Write-one-to-clear mask for this cycle's BTN_EDGE write.
  always_comb begin
    edge_clr = '0;
    if (wr && (ofs == OFS_BTN_EDGE)) begin
      edge_clr = wbits[NUM_BTN-1:0];
    end
  end

  // Sticky rising-edge flags; a new edge wins over a coincident clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_edge <= '0;
    end else begin
      btn_edge <= (btn_edge & ~edge_clr) | rise;
    end
  end

  // Interrupt enable register, byte-lane masked.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en <= '0;
    end else if (wr && (ofs == OFS_IRQ_EN)) begin
      irq_en <= (irq_en & ~be_mask[NUM_BTN-1:0]) | wbits[NUM_BTN-1:0];
    end
  end

  // LED register with direct, set and clear write ports.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_out <= '0;
    end else if (wr) begin
      case (ofs)
        OFS_LED_OUT: led_out <= (led_out & ~be_mask[NUM_LED-1:0]) | wbits[NUM_LED-1:0];
        OFS_LED_SET: led_out <= led_out | wbits[NUM_LED-1:0];
        OFS_LED_CLR: led_out <= led_out & ~wbits[NUM_LED-1:0];
        default:     led_out <= led_out;
      endcase
    end
  end

  // Interrupt is a pure function of registered state.
  assign io_irq = |(btn_edge & irq_en);

  // ---------------------------------------------------------------------
  // Optional blink prescaler
  // ---------------------------------------------------------------------
`ifdef IO_GPIO_BLINK_EN
  logic [NUM_LED-1:0] blink_mask;
  logic [15:0]        blink_div;
  logic [15:0]        presc;
  logic               phase;

  // Blink configuration registers, byte-lane masked.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_mask <= '0;
      blink_div  <= '0;
    end else if (wr) begin
      if (ofs == OFS_BLINK_MASK) begin
        blink_mask <= (blink_mask & ~be_mask[NUM_LED-1:0]) | wbits[NUM_LED-1:0];
      end
      if (ofs == OFS_BLINK_DIV) begin
        blink_div <= (blink_div & ~be_mask[15:0]) | wbits[15:0];
      end
    end
  end

  // Prescaler counts 0..blink_div and flips the phase on wrap; a zero
  // divider parks the phase high so masked LEDs simply follow LED_OUT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
      phase <= 1'b0;
    end else if (blink_div == 16'd0) begin
      presc <= '0;
      phase <= 1'b1;
    end else if (presc >= blink_div) begin
      presc <= '0;
      phase <= ~phase;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  assign leds = led_out & ~(blink_mask & ~{NUM_LED{phase}});
`else
  assign leds = led_out;
`endif

  // ---------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------
  logic [31:0] rd_val;

  // Read multiplexer; write-only and unmapped offsets return zero.
  always_comb begin
    rd_val = '0;
    case (ofs)
      OFS_BTN_IN:     rd_val[NUM_BTN-1:0] = deb;
      OFS_BTN_EDGE:   rd_val[NUM_BTN-1:0] = btn_edge;
      OFS_IRQ_EN:     rd_val[NUM_BTN-1:0] = irq_en;
      OFS_LED_OUT:    rd_val[NUM_LED-1:0] = led_out;
`ifdef IO_GPIO_BLINK_EN
      OFS_BLINK_MASK: rd_val[NUM_LED-1:0] = blink_mask;
      OFS_BLINK_DIV:  rd_val[15:0]        = blink_div;
`else
      OFS_BLINK_MASK, OFS_BLINK_DIV: rd_val = '0;
`endif
      OFS_LED_SET, OFS_LED_CLR: rd_val = '0;
      default:        rd_val = '0;
    endcase
  end

  // Registered read data, presented one clock after the address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      io_rdata <= '0;
    end else begin
      io_rdata <= sel ? rd_val : 32'd0;
    end
  end

endmodule
